// File: rtl/sel_arbiter.sv
// sel_arbiter: round-robin owner of the shared 2-bit mux/decode/XOR
// datapath. It grants one of two requesters, drives the datapath operands
// and select, waits SETTLE_CYCLES, captures the registered XOR outputs and
// returns them to the winner with a one-cycle ack.
//
// Parameters:
//   SETTLE_CYCLES - cycles spent in SETTLE before capture (1..15)
// Ports:
//   Clock, Reset_n      - clock, synchronous active-low reset
//   req_a/op_a          - requester A handshake and operand code
//   req_b/op_b          - requester B handshake and operand code
//   ack_a/ack_b         - one-cycle completion pulses
//   rsp_data            - {b_xor,a_xor}, valid while an ack is high
//   busy                - high whenever the FSM is not IDLE
//   dp_a/dp_b/dp_sel    - datapath operand and select drives
//   dp_a_xor/dp_b_xor   - registered XOR results from the datapath
// Optional build macro:
//   SELARB_STATS_EN     - adds saturating grant counters gnt_cnt_a/gnt_cnt_b

module sel_arbiter #(
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic       Clock,
    input  logic       Reset_n,
    input  logic       req_a,
    input  logic [1:0] op_a,
    input  logic       req_b,
    input  logic [1:0] op_b,
    output logic       ack_a,
    output logic       ack_b,
    output logic [1:0] rsp_data,
    output logic       busy,
    output logic [1:0] dp_a,
    output logic [1:0] dp_b,
    output logic       dp_sel,
    input  logic       dp_a_xor,
    input  logic       dp_b_xor
`ifdef SELARB_STATS_EN
    ,
    output logic [7:0] gnt_cnt_a,
    output logic [7:0] gnt_cnt_b
`endif
);

    localparam logic [3:0] LP_LOAD = 4'(SETTLE_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_GRANT,
        S_SETTLE,
        S_CAPTURE,
        S_RESP
    } state_t;

    state_t     r_state;
    state_t     w_next;
    logic [3:0] r_cnt;
    logic       r_last_b;
    logic       r_sel;
    logic [1:0] r_dp_a;
    logic [1:0] r_dp_b;
    logic [1:0] r_rsp;
    logic       r_ack_a;
    logic       r_ack_b;
    logic       w_any;
    logic       w_win_b;
    logic       w_grant;
    logic       w_busy;

    // B wins when it is alone, or on a tie when A had the last grant.
    assign w_any   = req_a | req_b;
    assign w_win_b = req_b & (~req_a | ~r_last_b);
    assign w_grant = (r_state == S_IDLE) & w_any;

    // State register
    always_ff @(posedge Clock) begin
        if (!Reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:    if (w_any) w_next = S_GRANT;
            S_GRANT:   w_next = S_SETTLE;
            S_SETTLE:  if (r_cnt == 4'd0) w_next = S_CAPTURE;
            S_CAPTURE: w_next = S_RESP;
            S_RESP:    w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        w_busy = 1'b1;
        if (r_state == S_IDLE) w_busy = 1'b0;
    end

    // Datapath drives, settle counter, response capture and ack pulses.
    always_ff @(posedge Clock) begin
        if (!Reset_n) begin
            r_cnt    <= 4'd0;
            r_last_b <= 1'b1;
            r_sel    <= 1'b0;
            r_dp_a   <= 2'b00;
            r_dp_b   <= 2'b00;
            r_rsp    <= 2'b00;
            r_ack_a  <= 1'b0;
            r_ack_b  <= 1'b0;
        end else begin
            r_ack_a <= 1'b0;
            r_ack_b <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_sel    <= w_win_b;
                        r_last_b <= w_win_b;
                        if (w_win_b) r_dp_b <= op_b;
                        else         r_dp_a <= op_a;
                    end
                end
                S_GRANT: begin
                    r_cnt <= LP_LOAD;
                end
                S_SETTLE: begin
                    if (r_cnt != 4'd0) r_cnt <= r_cnt - 4'd1;
                end
                S_CAPTURE: begin
                    r_rsp   <= {dp_b_xor, dp_a_xor};
                    r_ack_a <= ~r_sel;
                    r_ack_b <= r_sel;
                end
                default: ;
            endcase
        end
    end

`ifdef SELARB_STATS_EN
    logic [7:0] r_cnt_a;
    logic [7:0] r_cnt_b;

    always_ff @(posedge Clock) begin
        if (!Reset_n) begin
            r_cnt_a <= 8'd0;
            r_cnt_b <= 8'd0;
        end else if (w_grant) begin
            if (w_win_b) begin
                if (r_cnt_b != 8'hFF) r_cnt_b <= r_cnt_b + 8'd1;
            end else begin
                if (r_cnt_a != 8'hFF) r_cnt_a <= r_cnt_a + 8'd1;
            end
        end
    end

    assign gnt_cnt_a = r_cnt_a;
    assign gnt_cnt_b = r_cnt_b;
`else
    logic w_unused;
    assign w_unused = w_grant;
`endif

    assign ack_a    = r_ack_a;
    assign ack_b    = r_ack_b;
    assign rsp_data = r_rsp;
    assign busy     = w_busy;
    assign dp_a     = r_dp_a;
    assign dp_b     = r_dp_b;
    assign dp_sel   = r_sel;

endmodule

// File: tb/tb_sel_arbiter.sv
// tb_sel_arbiter: self-checking bench for sel_arbiter with three instances
// (SETTLE_CYCLES = 2, 1, 15) each driving a small datapath stand-in.

module tb_sel_arbiter;

    localparam int unsigned SC [3] = '{2, 1, 15};

    logic       clk;
    logic       rst_n;
    logic       ra  [3];
    logic       rb  [3];
    logic [1:0] oa  [3];
    logic [1:0] ob  [3];
    logic       aa  [3];
    logic       ab  [3];
    logic [1:0] rsp [3];
    logic       bsy [3];
    logic [1:0] da  [3];
    logic [1:0] db  [3];
    logic       ds  [3];
`ifdef SELARB_STATS_EN
    logic [7:0] ca  [3];
    logic [7:0] cb  [3];
`endif

    int checks = 0;
    int errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Datapath stand-in: mux the selected operand, one-hot decode it, and
    // XOR-reduce the low and high decode pairs into registered outputs.
    // Result: {b_xor,a_xor} = {m[1], ~m[1]}.
    for (genvar g = 0; g < 3; g++) begin : g_dut
        logic       xa;
        logic       xb;
        logic [1:0] m;
        logic [3:0] dec;
        assign m   = ds[g] ? db[g] : da[g];
        assign dec = 4'b0001 << m;
        always_ff @(posedge clk) begin
            xa <= dec[0] ^ dec[1];
            xb <= dec[2] ^ dec[3];
        end
        sel_arbiter #(.SETTLE_CYCLES(SC[g])) u_dut (
            .Clock    (clk),
            .Reset_n  (rst_n),
            .req_a    (ra[g]),
            .op_a     (oa[g]),
            .req_b    (rb[g]),
            .op_b     (ob[g]),
            .ack_a    (aa[g]),
            .ack_b    (ab[g]),
            .rsp_data (rsp[g]),
            .busy     (bsy[g]),
            .dp_a     (da[g]),
            .dp_b     (db[g]),
            .dp_sel   (ds[g]),
            .dp_a_xor (xa),
            .dp_b_xor (xb)
`ifdef SELARB_STATS_EN
            ,
            .gnt_cnt_a(ca[g]),
            .gnt_cnt_b(cb[g])
`endif
        );
    end

    typedef struct {
        logic       qa;
        logic [1:0] pa;
        logic       qb;
        logic [1:0] pb;
        logic       wb;
        logic [1:0] r;
    } vec_t;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string n, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", n, act, exp);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            ra[i] = 1'b0;
            rb[i] = 1'b0;
        end
        repeat (2) tick();
        rst_n = 1'b1;
    endtask

    // Issue one transaction right after an edge (E0) and run it to the ack.
    // lat counts edges from E0 to the edge after which ack is seen.
    task automatic txn(
        input  int         k,
        input  logic       qa,
        input  logic [1:0] pa,
        input  logic       qb,
        input  logic [1:0] pb,
        input  logic       early,
        input  logic       keep,
        output int         lat,
        output logic       wb,
        output logic [1:0] r,
        output logic       sel,
        output logic [1:0] dop,
        output logic       oh,
        output logic       clr
    );
        ra[k] = qa;
        rb[k] = qb;
        oa[k] = pa;
        ob[k] = pb;
        lat = 0;
        sel = 1'b0;
        dop = 2'b00;
        do begin
            tick();
            lat++;
            if (lat == 1 && early) begin
                ra[k] = 1'b0;
                rb[k] = 1'b0;
            end
            if (lat == 2) begin
                sel = ds[k];
                dop = ds[k] ? db[k] : da[k];
            end
        end while (!(aa[k] | ab[k]) && lat < 40);
        wb = ab[k];
        r  = rsp[k];
        oh = aa[k] ^ ab[k];
        if (!keep) begin
            ra[k] = 1'b0;
            rb[k] = 1'b0;
        end else if (wb) begin
            rb[k] = 1'b0;
        end else begin
            ra[k] = 1'b0;
        end
        tick();
        clr = !(aa[k] | ab[k]);
    endtask

    function automatic logic [1:0] ref_rsp(input logic [1:0] op);
        // Operand codes 0/1 decode into the low pair, 2/3 into the high pair.
        return (op >= 2'd2) ? 2'b10 : 2'b01;
    endfunction

    initial begin
        vec_t       tbl [7];
        int         lat;
        logic       wb;
        logic [1:0] r;
        logic       sel;
        logic [1:0] dop;
        logic       oh;
        logic       clr;
        logic       lastb;
        logic       expb;
        int         n;

        tbl[0] = '{qa:1, pa:2'b00, qb:0, pb:2'b00, wb:0, r:2'b01};
        tbl[1] = '{qa:1, pa:2'b11, qb:0, pb:2'b00, wb:0, r:2'b10};
        tbl[2] = '{qa:0, pa:2'b00, qb:1, pb:2'b10, wb:1, r:2'b10};
        tbl[3] = '{qa:0, pa:2'b00, qb:1, pb:2'b01, wb:1, r:2'b01};
        tbl[4] = '{qa:1, pa:2'b01, qb:1, pb:2'b10, wb:0, r:2'b01};
        tbl[5] = '{qa:1, pa:2'b10, qb:1, pb:2'b11, wb:1, r:2'b10};
        tbl[6] = '{qa:1, pa:2'b11, qb:1, pb:2'b00, wb:0, r:2'b10};

        for (int i = 0; i < 3; i++) begin
            ra[i] = 1'b0;
            rb[i] = 1'b0;
            oa[i] = 2'b00;
            ob[i] = 2'b00;
        end

        // Reset held with req_a high: nothing may move.
        rst_n = 1'b0;
        ra[0] = 1'b1;
        repeat (3) tick();
        chk("rst_ack", int'(aa[0] | ab[0]), 0);
        chk("rst_busy", int'(bsy[0]), 0);
        chk("rst_dp", int'({da[0], db[0], ds[0]}), 0);
        chk("rst_rsp", int'(rsp[0]), 0);
        rst_n = 1'b1;
        txn(0, 1, 2'b00, 0, 2'b00, 0, 0, lat, wb, r, sel, dop, oh, clr);
        chk("rst_rel_lat", lat, 5);
        chk("rst_rel_win", int'(wb), 0);
        chk("rst_rel_rsp", int'(r), 1);

        // Table: sequential transactions from a fresh reset.
        do_reset();
        for (int i = 0; i < 7; i++) begin
            txn(0, tbl[i].qa, tbl[i].pa, tbl[i].qb, tbl[i].pb, 0, 0,
                lat, wb, r, sel, dop, oh, clr);
            chk($sformatf("tbl%0d_lat", i), lat, 5);
            chk($sformatf("tbl%0d_win", i), int'(wb), int'(tbl[i].wb));
            chk($sformatf("tbl%0d_rsp", i), int'(r), int'(tbl[i].r));
            chk($sformatf("tbl%0d_sel", i), int'(sel), int'(tbl[i].wb));
            chk($sformatf("tbl%0d_dop", i), int'(dop),
                int'(tbl[i].wb ? tbl[i].pb : tbl[i].pa));
            chk($sformatf("tbl%0d_onehot", i), int'(oh), 1);
            chk($sformatf("tbl%0d_pulse", i), int'(clr), 1);
        end

        // Tie from reset: A first, one IDLE cycle, then B.
        do_reset();
        txn(0, 1, 2'b01, 1, 2'b10, 0, 1, lat, wb, r, sel, dop, oh, clr);
        chk("tie_a_lat", lat, 5);
        chk("tie_a_win", int'(wb), 0);
        chk("tie_a_rsp", int'(r), 1);
        txn(0, 0, 2'b01, 1, 2'b10, 0, 0, lat, wb, r, sel, dop, oh, clr);
        chk("tie_b_lat", lat, 5);
        chk("tie_b_win", int'(wb), 1);
        chk("tie_b_sel", int'(sel), 1);
        chk("tie_b_rsp", int'(r), 2);

        // Fairness: both requests held; grants must alternate.
        do_reset();
        ra[0] = 1'b1;
        rb[0] = 1'b1;
        oa[0] = 2'b01;
        ob[0] = 2'b11;
        expb = 1'b0;
        n = 0;
        for (int c = 0; c < 200 && n < 6; c++) begin
            tick();
            if (aa[0] | ab[0]) begin
                chk($sformatf("fair%0d_onehot", n), int'(aa[0] ^ ab[0]), 1);
                chk($sformatf("fair%0d_win", n), int'(ab[0]), int'(expb));
                expb = ~expb;
                n++;
            end
        end
        chk("fair_count", n, 6);
        ra[0] = 1'b0;
        rb[0] = 1'b0;

        // Reset in SETTLE aborts without an ack.
        do_reset();
        ra[0] = 1'b1;
        oa[0] = 2'b11;
        repeat (3) tick();
        chk("mid_busy", int'(bsy[0]), 1);
        rst_n = 1'b0;
        tick();
        chk("mid_rst_busy", int'(bsy[0]), 0);
        chk("mid_rst_ack", int'(aa[0] | ab[0]), 0);
        rst_n = 1'b1;
        txn(0, 1, 2'b11, 0, 2'b00, 0, 0, lat, wb, r, sel, dop, oh, clr);
        chk("mid_reissue_lat", lat, 5);
        chk("mid_reissue_rsp", int'(r), 2);

        // Settle-time boundaries.
        do_reset();
        txn(1, 1, 2'b10, 0, 2'b00, 0, 0, lat, wb, r, sel, dop, oh, clr);
        chk("s1_lat", lat, 4);
        chk("s1_rsp", int'(r), 2);
        txn(2, 0, 2'b00, 1, 2'b01, 0, 0, lat, wb, r, sel, dop, oh, clr);
        chk("s15_lat", lat, 18);
        chk("s15_win", int'(wb), 1);
        chk("s15_rsp", int'(r), 1);

        // Random transactions against the arbitration model.
        do_reset();
        lastb = 1'b1;
        for (int i = 0; i < 40; i++) begin
            logic [1:0] q;
            logic [1:0] pa;
            logic [1:0] pb;
            logic       early;
            int         k;
            q     = 2'($urandom_range(1, 3));
            pa    = 2'($urandom_range(0, 3));
            pb    = 2'($urandom_range(0, 3));
            early = ($urandom_range(0, 7) == 0);
            k     = $urandom_range(0, 1);
            expb  = q[1] && (!q[0] || !lastb);
            if (k == 0) lastb = expb;
            if (k == 0) begin
                txn(0, q[0], pa, q[1], pb, early, 0,
                    lat, wb, r, sel, dop, oh, clr);
                chk($sformatf("rnd%0d_lat", i), lat, 5);
                chk($sformatf("rnd%0d_win", i), int'(wb), int'(expb));
                chk($sformatf("rnd%0d_rsp", i), int'(r),
                    int'(ref_rsp(expb ? pb : pa)));
                chk($sformatf("rnd%0d_pulse", i), int'(clr), 1);
            end else begin
                tick();
                chk($sformatf("rnd%0d_idle", i), int'(bsy[0]), 0);
            end
        end

`ifdef SELARB_STATS_EN
        // 300 grants to B saturate its counter at 255.
        do_reset();
        chk("stat_rst_a", int'(ca[1]), 0);
        chk("stat_rst_b", int'(cb[1]), 0);
        rb[1] = 1'b1;
        ob[1] = 2'b01;
        n = 0;
        for (int c = 0; c < 3000 && n < 300; c++) begin
            tick();
            if (ab[1]) n++;
        end
        rb[1] = 1'b0;
        repeat (3) tick();
        chk("stat_grants", n, 300);
        chk("stat_sat_b", int'(cb[1]), 255);
        chk("stat_a", int'(ca[1]), 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
